fifo_uart_tx: RTL and testbench

- Read-side consumer of the dual-clock FIFO. Runs in the FIFO read domain and uses the FIFO's empty, rdata and rinc handshake.
- Pops one word at a time and serialises it onto a UART-style line: start bit, data LSB first, optional parity, then stop bit(s).
- Drives the board-level TX pin. It is the next stage after the FIFO in the write→FIFO→serial-out chain.

---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/fifo_uart_baud_cnt.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 150 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// -----------------------------------------------------------------------------
// fifo_uart_pkg
// Shared types and helpers for the FIFO-fed UART transmitter.
//   tx_state_t   : frame sequencer states
//   calc_parity  : parity of a data word, even (odd=0) or odd (odd=1)
// -----------------------------------------------------------------------------
package fifo_uart_pkg;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended, which leaves their XOR reduction unchanged.
    localparam int unsigned MAX_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// fifo_uart_baud_cnt
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; bit_end marks the
// last cycle of each bit period.
//   rclk    in  : clock
//   rrst_n  in  : asynchronous active-low reset
//   clear   in  : hold the count at 0 (used while the transmitter is idle)
//   bit_end out : high on the final cycle of a bit period
// -----------------------------------------------------------------------------
module fifo_uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic rclk,
    input  logic rrst_n,
    input  logic clear,
    output logic bit_end
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_end = (cnt == LAST);

    // Wrapping at bit_end means every state change (which only happens at
    // bit_end) lands on a fresh count of 0.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Read-side consumer of the dual-clock FIFO: pops one word per frame and
// serialises it as start bit, data LSB first, optional parity, stop bit(s).
//   rclk    in  : read-domain clock
//   rrst_n  in  : asynchronous active-low reset (abandons any frame)
//   enable  in  : allows a new frame to start; only looked at in IDLE
//   empty   in  : FIFO empty flag (rclk domain)
//   rdata   in  : FIFO head word, valid while empty=0 (show-ahead)
//   rinc    out : FIFO pop strobe, one cycle per frame
//   txd     out : serial line, idles high
//   busy    out : high while a frame is in progress
//   tx_done out : one-cycle pulse after the last stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be 2 or more");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("fifo_uart_tx: PARITY_EN must be 0 or 1");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
        $error("fifo_uart_tx: DATA_WIDTH out of range");
    end

    // Bit counter indexes data bits and, reused, stop bits.
    localparam int              BIT_W     = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    tx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  parity_bit;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_end;

    assign shift_next = shift_reg >> 1;

    // Pop strobe is combinational so the FIFO advances in the same cycle the
    // word is captured. Gated by rrst_n so no word is lost while in reset.
    assign rinc = rrst_n & (state == IDLE) & enable & ~empty;

    fifo_uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .clear   (state == IDLE),
        .bit_end (bit_end)
    );

    // txd is loaded with the next bit's value on the cycle that ends the
    // current bit, so it shows that value on the first cycle of the new state.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (enable && !empty) begin
                        shift_reg  <= rdata;
                        parity_bit <= calc_parity(MAX_DATA_WIDTH'(rdata), 1'(PARITY_ODD));
                        bit_cnt    <= '0;
                        txd        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd   <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                txd   <= parity_bit;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            txd     <= shift_next[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            tx_done <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Three transmitters share one clock, reset, enable and word stream:
//   inst 0 : no parity, 1 stop bit   (frame 40 cycles)
//   inst 1 : even parity, 1 stop bit (frame 44 cycles)
//   inst 2 : odd parity, 2 stop bits (frame 48 cycles)
// Each has its own show-ahead FIFO read pointer and a reference model that
// predicts rinc/txd/busy/tx_done every cycle from the frame rules.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int N   = 3;

    logic       rclk;
    logic       rrst_n;
    logic       enable;
    logic [N-1:0] empty, rinc, txd, busy, tx_done;
    logic [7:0] rdata [N];

    logic [7:0] fmem [64];
    int         wr_ptr = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int PE = (g == 0) ? 0 : 1;
        localparam int PO = (g == 2) ? 1 : 0;
        localparam int SB = (g == 2) ? 2 : 1;
        localparam int L  = (1 + 8 + PE + SB) * CPB;

        int   rd_ptr = 0;
        int   rem = 0;
        bit   done_due = 1'b0;
        logic frame [16];

        fifo_uart_tx #(
            .DATA_WIDTH   (8),
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PE),
            .PARITY_ODD   (PO),
            .STOP_BITS    (SB)
        ) u_dut (
            .rclk    (rclk),
            .rrst_n  (rrst_n),
            .enable  (enable),
            .empty   (empty[g]),
            .rdata   (rdata[g]),
            .rinc    (rinc[g]),
            .txd     (txd[g]),
            .busy    (busy[g]),
            .tx_done (tx_done[g])
        );

        // Show-ahead FIFO: head word always presented, advanced after a pop.
        assign empty[g] = (rd_ptr == wr_ptr);
        assign rdata[g] = fmem[rd_ptr[5:0]];

        always @(posedge rclk) begin
            if (rinc[g] === 1'b1) begin
                #1;
                rd_ptr = rd_ptr + 1;
            end
        end

        // Reference model: rem counts remaining line cycles of the current
        // frame; the frame bit on the line is frame[(L-rem)/CPB].
        always @(negedge rclk) begin
            logic exp_rinc;
            logic exp_txd;
            if (!rrst_n) begin
                rem      = 0;
                done_due = 1'b0;
                check($sformatf("i%0d reset txd", g), 32'(txd[g]), 32'd1);
                check($sformatf("i%0d reset rinc", g), 32'(rinc[g]), 32'd0);
                check($sformatf("i%0d reset busy", g), 32'(busy[g]), 32'd0);
                check($sformatf("i%0d reset tx_done", g), 32'(tx_done[g]), 32'd0);
            end else begin
                exp_rinc = (rem == 0) && (enable === 1'b1) && (empty[g] === 1'b0);
                exp_txd  = (rem > 0) ? frame[(L - rem) / CPB] : 1'b1;
                check($sformatf("i%0d rinc", g), 32'(rinc[g]), 32'(exp_rinc));
                check($sformatf("i%0d txd", g), 32'(txd[g]), 32'(exp_txd));
                check($sformatf("i%0d busy", g), 32'(busy[g]), 32'(rem > 0));
                check($sformatf("i%0d tx_done", g), 32'(tx_done[g]), 32'(done_due));
                done_due = 1'b0;
                if (rem > 0) begin
                    rem = rem - 1;
                    if (rem == 0) done_due = 1'b1;
                end
                if (exp_rinc) begin
                    for (int j = 0; j < 16; j++) frame[j] = 1'b1;
                    frame[0] = 1'b0;
                    for (int b = 0; b < 8; b++) frame[1 + b] = rdata[g][b];
                    if (PE != 0) frame[9] = (^rdata[g]) ^ (PO != 0);
                    rem = L;
                end
            end
        end
    end

    // Advance n clocks and land 2 time units after the posedge.
    task automatic step(input int n);
        repeat (n) @(posedge rclk);
        #2;
    endtask

    task automatic push(input logic [7:0] w);
        fmem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (busy[0] !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check("busy rise within budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        rrst_n = 1'b1;
        enable = 1'b1;
        #1 rrst_n = 1'b0;
        step(3);
        rrst_n = 1'b1;

        // Empty FIFO with enable high: nothing may pop.
        step(100);

        // Single byte 0xA5 on all three configurations.
        push(8'hA5);
        step(60);

        // Back-to-back bytes: one idle cycle between frames.
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        step(170);

        // Enable dropped mid-DATA: frame completes, second byte waits.
        push(8'h3C);
        push(8'hC3);
        wait_busy(10);
        step(8);
        enable = 1'b0;
        step(150);
        enable = 1'b1;
        step(120);

        // Reset mid-DATA: line returns high at once; aborted word is dropped.
        push(8'h5A);
        push(8'h96);
        wait_busy(10);
        step(12);
        rrst_n = 1'b0;
        #1;
        check("async reset txd", 32'(txd), 32'h7);
        check("async reset busy", 32'(busy), 32'h0);
        check("async reset rinc", 32'(rinc), 32'h0);
        step(2);
        rrst_n = 1'b1;
        step(120);

        // Random words with random enable gaps.
        for (int c = 0; c < 300; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0 && wr_ptr < 50) push(8'($urandom));
            step(1);
        end
        enable = 1'b1;

        n = 0;
        while (n < 3000 && (busy !== 3'b000 || g_inst[0].rd_ptr != wr_ptr ||
                            g_inst[1].rd_ptr != wr_ptr || g_inst[2].rd_ptr != wr_ptr)) begin
            step(1);
            n++;
        end
        check("drain within budget", 32'(n < 3000), 32'd1);
        step(5);
        check("i0 words popped", 32'(g_inst[0].rd_ptr), 32'(wr_ptr));
        check("i1 words popped", 32'(g_inst[1].rd_ptr), 32'(wr_ptr));
        check("i2 words popped", 32'(g_inst[2].rd_ptr), 32'(wr_ptr));
        check("line idle at end", 32'(txd), 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
